// File: rtl/crash_sequencer_pkg.sv
// Shared types and constants for the crash (security-violation) sequencer.
// Contents:
//   crash_state_e   - sequencer FSM states
//   crash_cause_t   - wide-enough source index for up to 8 violation sources
//   CRASH_TRAP_ADDR - default redirect target
//   sat_inc8        - saturating 8-bit increment for the violation counter
//   idx_width       - index width for an N-entry vector (never below 1 bit)
package crash_sequencer_pkg;

  localparam int unsigned CRASH_VLEN = 64;
  localparam logic [CRASH_VLEN-1:0] CRASH_TRAP_ADDR = 64'h0000_0000_0000_0000;
  localparam int unsigned CRASH_CAUSE_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } crash_state_e;

  typedef logic [CRASH_CAUSE_W-1:0] crash_cause_t;

  // Counter stops at all-ones instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/crash_sequencer_rr_arbiter.sv
// rr_arbiter_onehot: purely combinational round-robin arbiter.
// Grants the first set request at an index >= rr_ptr, wrapping around.
// Ports:
//   req       in  NSRC  request vector
//   rr_ptr    in  PW    highest-priority index for this decision
//   grant     out NSRC  one-hot grant (all zero when no request)
//   grant_idx out PW    binary index of the granted bit (0 when none)
module rr_arbiter_onehot
  import crash_sequencer_pkg::*;
#(
  parameter int unsigned NSRC = 3,
  localparam int unsigned PW = idx_width(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NSRC-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  logic [PW:0] idx_s;
  logic        found_s;
  logic        hit_s;

  // Walk the request vector starting at rr_ptr; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    idx_s     = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      idx_s = {1'b0, rr_ptr} + (PW+1)'(k);
      idx_s = (idx_s >= (PW+1)'(NSRC)) ? (idx_s - (PW+1)'(NSRC)) : idx_s;
      hit_s = ~found_s & req[idx_s[PW-1:0]];
      grant[idx_s[PW-1:0]] = hit_s;
      grant_idx = hit_s ? idx_s[PW-1:0] : grant_idx;
      found_s   = found_s | hit_s;
    end
  end

endmodule

// File: rtl/crash_sequencer.sv
// crash_sequencer: arbitrates security-violation requests, issues one
// redirect-to-trap per episode over a valid/ready handshake, holds a pipeline
// flush for a drain window, counts violations and halts at a threshold.
// Optional build macro CRASH_LOG_EN adds a 4-entry {cause, pc} log with
// combinational readout (log_idx_i, log_pc_o, log_cause_o).
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   en_crash_i           global enable (0 masks all sources)
//   debug_mode_i         1 suppresses arbitration
//   viol_valid_i         per-source violation request
//   viol_pc_i            per-source PC, source i at [i*VLEN +: VLEN]
//   redir_valid_o/ready  redirect handshake to the frontend
//   redir_addr_o         constant TRAP_ADDR
//   flush_o, busy_o      flush request, FSM not idle
//   halt_o               sticky halt
//   cause_o, crash_pc_o  granted source index and PC (held)
//   crash_cnt_o          saturating violation count
module crash_sequencer
  import crash_sequencer_pkg::*;
#(
  parameter int unsigned NSRC         = 3,
  parameter int unsigned VLEN         = CRASH_VLEN,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned MAX_CRASH    = 255,
  parameter logic [VLEN-1:0] TRAP_ADDR = VLEN'(CRASH_TRAP_ADDR),
  localparam int unsigned CW = idx_width(NSRC)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_crash_i,
  input  logic                 debug_mode_i,
  input  logic [NSRC-1:0]      viol_valid_i,
  input  logic [NSRC*VLEN-1:0] viol_pc_i,
  output logic                 redir_valid_o,
  input  logic                 redir_ready_i,
  output logic [VLEN-1:0]      redir_addr_o,
  output logic                 flush_o,
  output logic                 busy_o,
  output logic                 halt_o,
  output logic [CW-1:0]        cause_o,
  output logic [VLEN-1:0]      crash_pc_o,
`ifdef CRASH_LOG_EN
  input  logic [1:0]           log_idx_i,
  output logic [VLEN-1:0]      log_pc_o,
  output logic [CW-1:0]        log_cause_o,
`endif
  output logic [7:0]           crash_cnt_o
);

  localparam int unsigned DW = idx_width(DRAIN_CYCLES);

  crash_state_e    state_r;
  logic [CW-1:0]   rr_ptr_r;
  logic [CW-1:0]   cause_r;
  logic [VLEN-1:0] crash_pc_r;
  logic [7:0]      cnt_r;
  logic [DW-1:0]   drain_r;
  logic            redir_valid_r;
  logic            flush_r;
  logic            busy_r;
  logic            halt_r;

  logic [NSRC-1:0] req_s;
  logic [NSRC-1:0] grant_s;
  logic [CW-1:0]   grant_idx_s;
  logic            grant_any_s;
  logic [CW-1:0]   rr_next_s;
  logic [VLEN-1:0] sel_pc_s;
  logic [8:0]      cnt_plus_s;
  logic            hit_max_s;
  logic            handshake_s;

  // Debug mode and a cleared enable both hide every source from the arbiter.
  assign req_s = viol_valid_i & {NSRC{en_crash_i & ~debug_mode_i}};

  rr_arbiter_onehot #(.NSRC(NSRC)) u_arb (
    .req       (req_s),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign grant_any_s = |grant_s;
  assign rr_next_s   = (grant_idx_s == CW'(NSRC-1)) ? '0 : (grant_idx_s + CW'(1));
  assign cnt_plus_s  = {1'b0, cnt_r} + 9'd1;
  assign hit_max_s   = (cnt_plus_s >= 9'(MAX_CRASH));
  assign handshake_s = (state_r == REQ) & redir_ready_i;

  // One-hot PC mux driven by the arbiter grant.
  always_comb begin
    sel_pc_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      sel_pc_s = grant_s[i] ? viol_pc_i[i*VLEN +: VLEN] : sel_pc_s;
    end
  end

  // Sequencer FSM with all visible outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= IDLE;
      rr_ptr_r      <= '0;
      cause_r       <= '0;
      crash_pc_r    <= '0;
      cnt_r         <= 8'd0;
      drain_r       <= '0;
      redir_valid_r <= 1'b0;
      flush_r       <= 1'b0;
      busy_r        <= 1'b0;
      halt_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_any_s) begin
            cause_r       <= grant_idx_s;
            crash_pc_r    <= sel_pc_s;
            rr_ptr_r      <= rr_next_s;
            redir_valid_r <= 1'b1;
            flush_r       <= 1'b1;
            busy_r        <= 1'b1;
            state_r       <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          // No abort path: valid stays up until the frontend takes it.
          if (redir_ready_i) begin
            cnt_r         <= sat_inc8(cnt_r);
            redir_valid_r <= 1'b0;
            drain_r       <= DW'(DRAIN_CYCLES-1);
            if (hit_max_s) begin
              halt_r  <= 1'b1;
              state_r <= HALT;
            end else begin
              state_r <= DRAIN;
            end
          end else begin
            state_r <= REQ;
          end
        end
        DRAIN: begin
          if (drain_r == '0) begin
            flush_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            drain_r <= drain_r - DW'(1);
          end
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          redir_valid_r <= 1'b0;
          flush_r       <= 1'b0;
          busy_r        <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  assign redir_valid_o = redir_valid_r;
  assign redir_addr_o  = TRAP_ADDR;
  assign flush_o       = flush_r;
  assign busy_o        = busy_r;
  assign halt_o        = halt_r;
  assign cause_o       = cause_r;
  assign crash_pc_o    = crash_pc_r;
  assign crash_cnt_o   = cnt_r;

`ifdef CRASH_LOG_EN
  logic [VLEN-1:0] log_pc_r    [4];
  logic [CW-1:0]   log_cause_r [4];
  logic [1:0]      log_wptr_r;

  // Circular log: every accepted redirect overwrites the oldest entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      log_wptr_r <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        log_pc_r[i]    <= '0;
        log_cause_r[i] <= '0;
      end
    end else if (handshake_s) begin
      log_pc_r[log_wptr_r]    <= crash_pc_r;
      log_cause_r[log_wptr_r] <= cause_r;
      log_wptr_r              <= log_wptr_r + 2'd1;
    end else begin
      log_wptr_r <= log_wptr_r;
    end
  end

  assign log_pc_o    = log_pc_r[log_idx_i];
  assign log_cause_o = log_cause_r[log_idx_i];
`else
  logic unused_hs_s;
  assign unused_hs_s = handshake_s;
`endif

endmodule

// File: doc/crash_sequencer.md
Name: crash_sequencer

Overview:
- Central controller for security-violation ("crash") handling in the execute stage.
- Collects violation requests from the branch unit, the bounds/overflow checker and the load-constraint checker, and arbitrates them round-robin.
- Drives a single redirect-to-trap request to the frontend with a valid/ready handshake, then holds a pipeline flush for a programmable drain window.
- Counts violations and enters a sticky halt once a threshold is reached.

Parameters:
NSRC, 3, number of violation sources (1..8)
VLEN, riscv::VLEN, PC width
DRAIN_CYCLES, 4, cycles flush_o stays high after the redirect handshake (>=1)
MAX_CRASH, 255, violation count that forces HALT (8-bit counter)
TRAP_ADDR, 0, redirect target address

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
en_crash_i  in  1  global enable; 0 masks all sources
debug_mode_i  in  1  1 suppresses arbitration (requests ignored, not queued)
viol_valid_i  in  NSRC  per-source violation pulse/level
viol_pc_i  in  NSRC*VLEN  PC of the offending instruction, source i at [i*VLEN +: VLEN]
redir_valid_o  out  1  redirect request to the frontend
redir_ready_i  in  1  frontend accepts the redirect
redir_addr_o  out  VLEN  redirect target (TRAP_ADDR)
flush_o  out  1  flush the scoreboard/issue stage
busy_o  out  1  FSM not in IDLE
halt_o  out  1  sticky halt; core must stop fetching
cause_o  out  $clog2(NSRC)  index of the granted source (held)
crash_pc_o  out  VLEN  PC of the granted violation (held)
crash_cnt_o  out  8  saturating violation count

Behaviour:
- Reset: FSM=IDLE, rr_ptr=0. All outputs 0, except redir_addr_o, which is constantly TRAP_ADDR.
- Masked request: req = viol_valid_i & {NSRC{en_crash_i & ~debug_mode_i}}.
- Arbitration (IDLE only, combinational):
  - Round-robin starting at rr_ptr; grant = first set bit at index >= rr_ptr, wrapping.
  - On grant g: cause_o<=g, crash_pc_o<=viol_pc_i[g], rr_ptr<=(g+1) mod NSRC, FSM->REQ next cycle. Outputs are registered, so latency is 1 cycle.
- REQ:
  - redir_valid_o=1, flush_o=1.
  - Hold until redir_valid_o&redir_ready_i. redir_valid_o must not drop before ready.
  - On handshake: crash_cnt_o<=sat(cnt+1), load drain counter with DRAIN_CYCLES-1, FSM->DRAIN.
  - If cnt+1>=MAX_CRASH, FSM->HALT instead.
- DRAIN:
  - redir_valid_o=0, flush_o=1; counter decrements.
  - At 0: FSM->IDLE, flush_o drops in the IDLE cycle.
  - Total flush_o high time = REQ cycles + DRAIN_CYCLES.
- HALT:
  - halt_o=1, flush_o=1, redir_valid_o=0. Terminal until reset.
- New requests in REQ/DRAIN/HALT are dropped. Sources hold their own state; a level-held request is re-arbitrated on return to IDLE.
- Simultaneous requests: exactly one grant per episode; the others wait by round-robin fairness.
- en_crash_i falling while in REQ: the handshake still completes (no abort). The enable only gates new grants.
- debug_mode_i has the same effect as en_crash_i=0.
- crash_cnt_o saturates at 255 and never wraps.
- Asynchronous reset mid-REQ returns to IDLE immediately; redir_valid_o deasserts without a handshake.
- busy_o = (FSM!=IDLE).

Optional Feature:
CRASH_LOG_EN
- Defined:
  - Adds a 4-entry circular log of {cause, pc}, written on each REQ handshake; the write pointer wraps at 4 and the oldest entry is overwritten.
  - Adds ports log_idx_i (2, in), log_pc_o (VLEN, out), log_cause_o ($clog2(NSRC), out) for combinational readout.
  - Entries reset to 0.
- Undefined: the ports and storage are absent; all other behaviour is identical.

Decomposition:
- ariane_pkg gains:
  - crash_state_e (IDLE, REQ, DRAIN, HALT);
  - crash_cause_t;
  - the constant CRASH_TRAP_ADDR.
- One sub-module, rr_arbiter_onehot: NSRC-wide round-robin grant given req and rr_ptr, purely combinational. It is reusable for the bop_unit sources.

Test Plan:
- Single request: en=1, viol_valid_i=3'b010, pc=0x8000_0100, redir_ready_i=1 after 3 cycles -> redir_valid_o high for 3 cycles, cause_o=1, crash_pc_o=0x8000_0100, flush_o high 3+4 cycles, crash_cnt_o=1, back to IDLE.
- Simultaneous request 3'b111 held with ready always 1 -> grants in order 0,1,2,0 (rr_ptr wraps); crash_cnt_o increments once per episode.
- Masking: en_crash_i=0 or debug_mode_i=1 with viol_valid_i=3'b001 -> no redir_valid_o, busy_o=0, count unchanged.
- Halt: MAX_CRASH=2, two accepted violations -> after the 2nd handshake halt_o=1, flush_o=1 stays, further requests ignored, only rst_ni clears.
- Reset mid-REQ: assert rst_ni=0 while redir_valid_o=1 and ready=0 -> all outputs 0 asynchronously, IDLE after release.
- CRASH_LOG_EN: 5 violations with pcs 0x100..0x500 -> log_idx 0 reads 0x500, idx 1..3 read 0x200..0x400.
